display_mux_n: RTL and testbench
================================

# display_mux_n

Parametrised, register-mapped multiplexed 7-segment display controller. It is the successor to the fixed 4-digit Basys3 display driver. It supports DIGITS digits, per-digit decimal points, per-digit blink, PWM brightness, a frame-sync pulse and fully registered outputs. It sits on the CPU I/O bus, between the peripheral write decode and the board's seg/dp/an pins.

## Interface
- DIGITS, 4: number of digits; power of two, 4 or 8.
- PRESCALE, 16: one digit slot lasts 2^PRESCALE clk cycles; must be ≥ 4; benches use 4.
- BLINK_BITS, 6: blink half-period is 2^(BLINK_BITS-1) frames.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe, one cycle per write.
- wr_addr  in  clog2(DIGITS)+1  0..DIGITS-1 address digit buffers; DIGITS+0..DIGITS+3 address control registers.
- wr_data  in  8  write data.
- seg  out  7  segments, active-low; bit0 = top, bit6 = middle.
- dp  out  1  decimal point, active-low.
- an  out  DIGITS  anodes, active-low; an[i] drives digit i, with digit 0 rightmost.
- frame_tick  out  1  one-cycle pulse when digit 0's slot begins.

## Operation
- Registers, all writable in one cycle. Reads are not supported.
  - buf[i]: character code for digit i.
  - MODE (DIGITS+0), bit0: 0 = pattern, 1 = raw.
  - BRIGHT (DIGITS+1), bits 3:0.
  - BLINK (DIGITS+2): per-digit blink mask, bit i = digit i.
  - DPMASK (DIGITS+3): per-digit decimal-point enable.
  - Bits above DIGITS in the BLINK and DPMASK masks are ignored.
- Reset values:
  - every buf = 0x10 (blank); MODE = 0; BRIGHT = 15; BLINK = 0; DPMASK = 0.
  - All counters = 0.
- Pattern mode: the code indexes the font.
  - 0x00-0x0F: hex digits 0-F.
  - 0x10: blank.
  - 0x11-0x17: '-', J, L, P, S, U, c.
  - 0x18: outer verticals. 0x19: top + bottom. 0x1A: inverted c. 0x1B: inverted C. 0x1C: three horizontals.
  - 0x1D-0xFF: blank.
- Raw mode:
  - seg = ~code[6:0].
  - code[7] lights the dp, in addition to DPMASK.
- dp is lit (0) when DPMASK[i] = 1, or when MODE = 1 and code[7] = 1.
- Scan counters:
  - slot_cnt, PRESCALE bits, free-running.
  - digit_idx, clog2(DIGITS) bits, increments when slot_cnt wraps; the wrap from DIGITS-1 to 0 ends a frame.
  - frame_cnt, BLINK_BITS bits, increments at each frame end.
- PWM:
  - Let sub = slot_cnt[PRESCALE-1:PRESCALE-4].
  - The anode for digit_idx is enabled while sub ≤ BRIGHT, giving a duty of (BRIGHT+1)/16.
  - BRIGHT = 15 means always on within the slot.
- Ghost suppression: all anodes are forced off during the first clk of every slot (slot_cnt = 0), whatever BRIGHT is.
- Blink: when BLINK[i] = 1 and frame_cnt[BLINK_BITS-1] = 1, the anode for digit i stays off for its whole slot.
- Blanked or off anode: seg, dp and an all drive 1.

## Timing
- seg, dp, an and frame_tick are all registered. Outputs reflect the counter state and register contents of the previous cycle.
- Write latency: a write in cycle t to the buffer of the currently scanned digit appears on seg in cycle t+2 (register update, then output register).
- Control-register writes take effect with the same latency.
- frame_tick is high for exactly one cycle: the cycle after slot_cnt = 0 with digit_idx = 0.
- Simultaneous wr_en and slot or frame wrap: the write still lands; counters are unaffected by writes.
- An out-of-range wr_addr (≥ DIGITS+4) is ignored.
- Output reset values: seg = 7'h7F, dp = 1, an = all ones, frame_tick = 0. These appear the cycle after reset is sampled high.
- Reset mid-frame: the scan restarts at digit 0 with slot_cnt = 0; the first frame_tick follows 1 cycle after reset deasserts.

## Structure
- Package display_pkg holds:
  - the font code constants (CH_0..CH_F, CH_BLANK = 0x10, CH_DASH = 0x11, …);
  - the register offsets MODE_OFS = 0, BRIGHT_OFS = 1, BLINK_OFS = 2, DPMASK_OFS = 3;
  - the reset-value constants.
- Sub-module display_font: combinational 8-bit code → 7-bit active-low segment ROM holding the 29 defined codes, with blank as the default.
- The top level contains the register file, the scan/PWM/blink counters and the output registers.

## Test plan
All scenarios use DIGITS = 4, PRESCALE = 4 (16-clk slot, 64-clk frame) and BLINK_BITS = 2.
- Reset, then idle 128 clks:
  - seg = 7'h7F and dp = 1 throughout.
  - an pulses 4'b1110, 1101, 1011, 0111 for 15 clks each, with a 1-clk all-off gap between.
  - frame_tick fires every 64 clks.
- Pattern mode: write buf0..3 = 0x00, 0x0A, 0x1C, 0x1D.
  - seg during the four slots = 7'h40, 7'h08, 7'h36, 7'h7F.
- Raw mode and dp: MODE = 1, buf1 = 0x81.
  - During digit 1: seg = 7'h7E and dp = 0.
  - Then DPMASK = 4'b0100: dp = 0 during digit 2 only.
- Brightness: BRIGHT = 3.
  - Each anode is low for exactly 3 clks per slot (sub 1..3; sub 0 is blanked).
  - BRIGHT = 0: every anode stays off.
- Blink: BLINK = 4'b0001.
  - Digit 0 is shown in frames 0-1 and dark in frames 2-3, repeating.
  - Other digits are unaffected.
- Reset mid-frame during digit 2: the next cycle shows all outputs at reset values; the scan resumes at digit 0; all registers are back at their defaults.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display controller:
// character codes, control-register offsets and reset values.
package display_pkg;

  localparam logic [7:0] CH_0 = 8'h00;
  localparam logic [7:0] CH_1 = 8'h01;
  localparam logic [7:0] CH_2 = 8'h02;
  localparam logic [7:0] CH_3 = 8'h03;
  localparam logic [7:0] CH_4 = 8'h04;
  localparam logic [7:0] CH_5 = 8'h05;
  localparam logic [7:0] CH_6 = 8'h06;
  localparam logic [7:0] CH_7 = 8'h07;
  localparam logic [7:0] CH_8 = 8'h08;
  localparam logic [7:0] CH_9 = 8'h09;
  localparam logic [7:0] CH_A = 8'h0A;
  localparam logic [7:0] CH_B = 8'h0B;
  localparam logic [7:0] CH_C = 8'h0C;
  localparam logic [7:0] CH_D = 8'h0D;
  localparam logic [7:0] CH_E = 8'h0E;
  localparam logic [7:0] CH_F = 8'h0F;
  localparam logic [7:0] CH_BLANK     = 8'h10;
  localparam logic [7:0] CH_DASH      = 8'h11;
  localparam logic [7:0] CH_J         = 8'h12;
  localparam logic [7:0] CH_L         = 8'h13;
  localparam logic [7:0] CH_P         = 8'h14;
  localparam logic [7:0] CH_S         = 8'h15;
  localparam logic [7:0] CH_U         = 8'h16;
  localparam logic [7:0] CH_C_LOW     = 8'h17;
  localparam logic [7:0] CH_VERT      = 8'h18;
  localparam logic [7:0] CH_TOP_BOT   = 8'h19;
  localparam logic [7:0] CH_INV_C_LOW = 8'h1A;
  localparam logic [7:0] CH_INV_C     = 8'h1B;
  localparam logic [7:0] CH_HORIZ     = 8'h1C;

  localparam int MODE_OFS   = 0;
  localparam int BRIGHT_OFS = 1;
  localparam int BLINK_OFS  = 2;
  localparam int DPMASK_OFS = 3;

  localparam logic [7:0] RST_BUF    = CH_BLANK;
  localparam logic       RST_MODE   = 1'b0;
  localparam logic [3:0] RST_BRIGHT = 4'hF;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

endpackage

// File: rtl/display_font.sv
// Character ROM: 8-bit code to active-low segments (bit0 = a/top .. bit6 = g/middle).
module display_font
  import display_pkg::*;
(
  input  logic [7:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      CH_0:         seg = 7'h40;
      CH_1:         seg = 7'h79;
      CH_2:         seg = 7'h24;
      CH_3:         seg = 7'h30;
      CH_4:         seg = 7'h19;
      CH_5:         seg = 7'h12;
      CH_6:         seg = 7'h02;
      CH_7:         seg = 7'h78;
      CH_8:         seg = 7'h00;
      CH_9:         seg = 7'h10;
      CH_A:         seg = 7'h08;
      CH_B:         seg = 7'h03;
      CH_C:         seg = 7'h46;
      CH_D:         seg = 7'h21;
      CH_E:         seg = 7'h06;
      CH_F:         seg = 7'h0E;
      CH_BLANK:     seg = SEG_BLANK;
      CH_DASH:      seg = 7'h3F;
      CH_J:         seg = 7'h61;
      CH_L:         seg = 7'h47;
      CH_P:         seg = 7'h0C;
      CH_S:         seg = 7'h12;
      CH_U:         seg = 7'h41;
      CH_C_LOW:     seg = 7'h27;
      CH_VERT:      seg = 7'h49;
      // the inverted glyphs are the 180-degree rotations of c and C
      CH_TOP_BOT:   seg = 7'h76;
      CH_INV_C_LOW: seg = 7'h3C;
      CH_INV_C:     seg = 7'h70;
      CH_HORIZ:     seg = 7'h36;
      default:      seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_mux_n.sv
// Register-mapped multiplexed 7-segment controller: digit buffers, control
// registers, scan/PWM/blink counters and fully registered pin outputs.
module display_mux_n
  import display_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 16,
  parameter int BLINK_BITS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DIGITS):0]  wr_addr,
  input  logic [7:0]               wr_data,
  output logic [6:0]               seg,
  output logic                     dp,
  output logic [DIGITS-1:0]        an,
  output logic                     frame_tick
);

  localparam int DW = $clog2(DIGITS);
  localparam int AW = DW + 1;

  logic [7:0]            digit_buf [DIGITS];
  logic                  mode_q;
  logic [3:0]            bright_q;
  logic [DIGITS-1:0]     blink_q;
  logic [DIGITS-1:0]     dpmask_q;

  logic [PRESCALE-1:0]   slot_cnt;
  logic [DW-1:0]         digit_idx;
  logic [BLINK_BITS-1:0] frame_cnt;

  logic [AW-1:0]         ctl_ofs;
  logic [7:0]            cur_code;
  logic [6:0]            font_seg;
  logic [3:0]            sub;
  logic                  blinked;
  logic                  lit;

  // Addresses at or above DIGITS+4 fall through every compare and are dropped.
  assign ctl_ofs = wr_addr - AW'(DIGITS);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) digit_buf[i] <= RST_BUF;
      mode_q   <= RST_MODE;
      bright_q <= RST_BRIGHT;
      blink_q  <= '0;
      dpmask_q <= '0;
    end else if (wr_en) begin
      if (wr_addr < AW'(DIGITS))               digit_buf[wr_addr[DW-1:0]] <= wr_data;
      else if (ctl_ofs == AW'(MODE_OFS))       mode_q   <= wr_data[0];
      else if (ctl_ofs == AW'(BRIGHT_OFS))     bright_q <= wr_data[3:0];
      else if (ctl_ofs == AW'(BLINK_OFS))      blink_q  <= wr_data[DIGITS-1:0];
      else if (ctl_ofs == AW'(DPMASK_OFS))     dpmask_q <= wr_data[DIGITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
      frame_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + PRESCALE'(1);
      if (slot_cnt == '1) begin
        digit_idx <= digit_idx + DW'(1);
        if (digit_idx == DW'(DIGITS - 1)) frame_cnt <= frame_cnt + BLINK_BITS'(1);
      end
    end
  end

  assign cur_code = digit_buf[digit_idx];

  display_font u_font (
    .code (cur_code),
    .seg  (font_seg)
  );

  // PWM compares the top four slot bits; slot_cnt == 0 is always dark to hide
  // the previous digit's segments while the anode switches.
  assign sub     = slot_cnt[PRESCALE-1 -: 4];
  assign blinked = blink_q[digit_idx] & frame_cnt[BLINK_BITS-1];
  assign lit     = (slot_cnt != '0) && (sub <= bright_q) && !blinked;

  always_ff @(posedge clk) begin
    if (reset) begin
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (slot_cnt == '0) && (digit_idx == '0);
      if (lit) begin
        seg <= mode_q ? ~cur_code[6:0] : font_seg;
        dp  <= ~(dpmask_q[digit_idx] | (mode_q & cur_code[7]));
        an  <= ~(DIGITS'(1) << digit_idx);
      end else begin
        seg <= SEG_BLANK;
        dp  <= 1'b1;
        an  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_display_mux_n.sv
// Self-checking bench for display_mux_n (4 digits, 16-clk slots, 4-frame blink period):
// a position-based reference model plus directed checks of the key waveforms.
module tb_display_mux_n;

  localparam int DIGITS     = 4;
  localparam int PRESCALE   = 4;
  localparam int BLINK_BITS = 2;
  localparam int SLOT       = 16;
  localparam int FRAME      = SLOT * DIGITS;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  display_mux_n #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLINK_BITS(BLINK_BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  // reference model state: m_pos = scan position the next edge sees
  int         m_pos;
  logic [7:0] m_buf [4];
  logic       m_mode;
  logic [3:0] m_bright, m_blink, m_dpmask;

  // observation statistics
  int         lit_cnt [4];
  int         dp_lo_cnt [4];
  logic [6:0] last_seg [4];
  int         ft_cnt, seg_on_cnt;
  logic [3:0] first_an;
  logic       seen_first;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // segment letters a..g lit -> active-low vector
  function automatic logic [6:0] glyph(input string s);
    logic [6:0] r;
    r = 7'h7F;
    for (int i = 0; i < s.len(); i++) r[3'(int'(s.getc(i)) - 97)] = 1'b0;
    return r;
  endfunction

  function automatic string font_ref(input logic [7:0] c);
    case (c)
      8'h00: return "abcdef";  8'h01: return "bc";      8'h02: return "abdeg";
      8'h03: return "abcdg";   8'h04: return "bcfg";    8'h05: return "acdfg";
      8'h06: return "acdefg";  8'h07: return "abc";     8'h08: return "abcdefg";
      8'h09: return "abcdfg";  8'h0A: return "abcefg";  8'h0B: return "cdefg";
      8'h0C: return "adef";    8'h0D: return "bcdeg";   8'h0E: return "adefg";
      8'h0F: return "aefg";    8'h11: return "g";       8'h12: return "bcde";
      8'h13: return "def";     8'h14: return "abefg";   8'h15: return "acdfg";
      8'h16: return "bcdef";   8'h17: return "deg";     8'h18: return "bcef";
      8'h19: return "ad";      8'h1A: return "abg";     8'h1B: return "abcd";
      8'h1C: return "adg";
      default: return "";
    endcase
  endfunction

  // {seg, dp, an, frame_tick} produced from scan position p
  function automatic logic [12:0] model_out(input int p);
    int         slot, dig;
    logic       on, ft, d;
    logic [7:0] code;
    logic [6:0] s;
    logic [3:0] a;
    slot = p % SLOT;
    dig  = (p / SLOT) % DIGITS;
    code = m_buf[dig];
    ft   = (p % FRAME) == 0;
    on   = (slot != 0) && (slot <= int'(m_bright)) &&
           !(m_blink[2'(dig)] && ((p / (FRAME * 2)) % 2 == 1));
    if (!on) return {7'h7F, 1'b1, 4'hF, ft};
    s = m_mode ? ~code[6:0] : glyph(font_ref(code));
    d = !(m_dpmask[2'(dig)] || (m_mode && code[7]));
    a = 4'hF;
    a[2'(dig)] = 1'b0;
    return {s, d, a, ft};
  endfunction

  task automatic model_reset();
    m_pos = 0;
    for (int i = 0; i < 4; i++) m_buf[i] = 8'h10;
    m_mode = 1'b0; m_bright = 4'hF; m_blink = 4'h0; m_dpmask = 4'h0;
  endtask

  task automatic model_write(input logic [2:0] a, input logic [7:0] d);
    if (a < 3'd4) m_buf[a[1:0]] = d;
    else if (a == 3'd4) m_mode = d[0];
    else if (a == 3'd5) m_bright = d[3:0];
    else if (a == 3'd6) m_blink = d[3:0];
    else m_dpmask = d[3:0];
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      lit_cnt[i] = 0; dp_lo_cnt[i] = 0; last_seg[i] = 'x;
    end
    ft_cnt = 0; seg_on_cnt = 0; first_an = 4'hF; seen_first = 1'b0;
  endtask

  // one clock: predict, pass the edge, compare at the falling edge
  task automatic cycle();
    logic [12:0] e;
    if (reset) begin
      e = {7'h7F, 1'b1, 4'hF, 1'b0};
      model_reset();
    end else begin
      e = model_out(m_pos);
      m_pos++;
      if (wr_en) model_write(wr_addr, wr_data);
    end
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard: observed empty queue expected one entry");
    end else begin
      e = exp_q.pop_front();
      chk("seg", 16'(seg), 16'(e[12:6]));
      chk("dp", 16'(dp), 16'(e[5]));
      chk("an", 16'(an), 16'(e[4:1]));
      chk("frame_tick", 16'(frame_tick), 16'(e[0]));
    end
    for (int i = 0; i < 4; i++) begin
      if (an[i] === 1'b0) begin
        lit_cnt[i]++;
        last_seg[i] = seg;
        if (dp === 1'b0) dp_lo_cnt[i]++;
      end
    end
    if (frame_tick === 1'b1) ft_cnt++;
    if (seg !== 7'h7F) seg_on_cnt++;
    if (!seen_first && an !== 4'hF) begin first_an = an; seen_first = 1'b1; end
  endtask

  // driver tasks
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic window(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic       reached;
    logic [7:0] rd;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    clear_stats();

    // reset and idle
    window(3);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'h1);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_ft", 16'(frame_tick), 16'h0);
    reset = 1'b0;
    clear_stats();
    cycle();
    chk("first_ft", 16'(frame_tick), 16'h1);
    window(127);
    for (int i = 0; i < 4; i++) chk("idle_lit", 16'(lit_cnt[i]), 16'd30);
    chk("idle_ft_cnt", 16'(ft_cnt), 16'd2);
    chk("idle_seg_dark", 16'(seg_on_cnt), 16'd0);
    chk("idle_first_an", 16'(first_an), 16'hE);

    // pattern mode
    wr(3'd0, 8'h00); wr(3'd1, 8'h0A); wr(3'd2, 8'h1C); wr(3'd3, 8'h1D);
    clear_stats();
    window(FRAME);
    chk("pat_d0", 16'(last_seg[0]), 16'h40);
    chk("pat_d1", 16'(last_seg[1]), 16'h08);
    chk("pat_d2", 16'(last_seg[2]), 16'h36);
    chk("pat_d3", 16'(last_seg[3]), 16'h7F);

    // raw mode and decimal points
    wr(3'd4, 8'h01); wr(3'd1, 8'h81);
    clear_stats();
    window(FRAME);
    chk("raw_seg_d1", 16'(last_seg[1]), 16'h7E);
    chk("raw_dp_d1", 16'(dp_lo_cnt[1]), 16'd15);
    chk("raw_dp_d0", 16'(dp_lo_cnt[0]), 16'd0);
    wr(3'd1, 8'h01); wr(3'd7, 8'hF4);
    clear_stats();
    window(FRAME);
    for (int i = 0; i < 4; i++) chk("dpmask", 16'(dp_lo_cnt[i]), (i == 2) ? 16'd15 : 16'd0);

    // brightness
    wr(3'd5, 8'h03);
    clear_stats();
    window(FRAME);
    for (int i = 0; i < 4; i++) chk("bright3", 16'(lit_cnt[i]), 16'd3);
    wr(3'd5, 8'h00);
    clear_stats();
    window(FRAME);
    for (int i = 0; i < 4; i++) chk("bright0", 16'(lit_cnt[i]), 16'd0);

    // blink on digit 0 over a full 4-frame period
    wr(3'd5, 8'h0F); wr(3'd6, 8'h01);
    clear_stats();
    window(FRAME * 4);
    for (int i = 0; i < 4; i++) chk("blink", 16'(lit_cnt[i]), (i == 0) ? 16'd30 : 16'd60);

    // randomized writes and occasional resets against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1; cycle(); reset = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        rd = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
        wr(3'($urandom_range(0, 7)), rd);
      end else begin
        cycle();
      end
    end

    // reset in the middle of digit 2
    wr(3'd4, 8'h01); wr(3'd2, 8'h55); wr(3'd5, 8'h07); wr(3'd6, 8'h0F); wr(3'd7, 8'h0F);
    reached = 1'b0;
    for (int i = 0; i < 80 && !reached; i++) begin
      if ((m_pos / SLOT) % DIGITS == 2 && m_pos % SLOT == 5) reached = 1'b1;
      else cycle();
    end
    chk("reach_digit2", 16'(reached), 16'h1);
    reset = 1'b1;
    cycle();
    chk("mid_rst_seg", 16'(seg), 16'h7F);
    chk("mid_rst_dp", 16'(dp), 16'h1);
    chk("mid_rst_an", 16'(an), 16'hF);
    chk("mid_rst_ft", 16'(frame_tick), 16'h0);
    reset = 1'b0;
    clear_stats();
    cycle();
    chk("mid_first_ft", 16'(frame_tick), 16'h1);
    window(FRAME - 1);
    for (int i = 0; i < 4; i++) chk("mid_lit", 16'(lit_cnt[i]), 16'd15);
    chk("mid_first_an", 16'(first_an), 16'hE);
    chk("mid_seg_dark", 16'(seg_on_cnt), 16'd0);
    chk("mid_dp_off", 16'(dp_lo_cnt[0] + dp_lo_cnt[1] + dp_lo_cnt[2] + dp_lo_cnt[3]), 16'd0);
    chk("mid_ft_cnt", 16'(ft_cnt), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
